// File: rtl/writeback_stage_if.sv
// MEM/WB boundary bundle: memory-stage results entering write-back and the
// register-file write port / status leaving it.
interface writeback_stage_if #(
    parameter int PC_W       = 9,
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5
);
    // memory stage -> write-back
    logic                  in_valid;
    logic                  stall;
    logic                  flush;
    logic [PC_W-1:0]       pcplus4;
    logic [31:0]           pcjump;
    logic [DATA_W-1:0]     aluresult;
    logic [DATA_W-1:0]     readdata;
    logic [RF_ADDRESS-1:0] rd;
    logic                  regwrite;
    logic [1:0]            memtoreg;
    logic [2:0]            readdatasel;

    // write-back -> register file / status
    logic                  rf_we;
    logic [RF_ADDRESS-1:0] rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic                  ld_misalign;
    logic [31:0]           retire_cnt;

    // Driver of the stage inputs (memory stage side)
    modport master (
        output in_valid, stall, flush, pcplus4, pcjump, aluresult, readdata,
               rd, regwrite, memtoreg, readdatasel,
        input  rf_we, rf_waddr, rf_wdata, ld_misalign, retire_cnt
    );

    // The write-back stage itself
    modport slave (
        input  in_valid, stall, flush, pcplus4, pcjump, aluresult, readdata,
               rd, regwrite, memtoreg, readdatasel,
        output rf_we, rf_waddr, rf_wdata, ld_misalign, retire_cnt
    );
endinterface

// File: rtl/writeback_stage.sv
// Write-back stage: MEM/WB pipeline register, load data extraction and
// extension, result selection, register-file write port, misaligned-load
// flag and retired-instruction counter.
module writeback_stage #(
    parameter int PC_W       = 9,
    parameter int DATA_W     = 32,
    parameter int RF_ADDRESS = 5
) (
    input  logic             clk,
    input  logic             reset,
    writeback_stage_if.slave wb
);
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int NBYTES = DATA_W / 8;
    localparam int NHALFS = DATA_W / 16;

    logic                  valid_reg;
    logic                  regwrite_reg;
    logic [RF_ADDRESS-1:0] rd_reg;
    logic [1:0]            memtoreg_reg;
    logic [2:0]            sel_reg;
    logic [DATA_W-1:0]     alu_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic [PC_W-1:0]       pc4_reg;
    logic [31:0]           pcjump_reg;
    logic [31:0]           retire_cnt_reg;

    // The held entry leaves the stage unless it is stalled; a flush on top of
    // a stall still pushes it out (it is replaced by a bubble).
    logic retire;
    assign retire = valid_reg & (~wb.stall | wb.flush);

    // Pipeline register: flush beats stall beats load; counter tracks retirements
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_reg      <= 1'b0;
            regwrite_reg   <= 1'b0;
            rd_reg         <= '0;
            memtoreg_reg   <= '0;
            sel_reg        <= '0;
            alu_reg        <= '0;
            rdata_reg      <= '0;
            pc4_reg        <= '0;
            pcjump_reg     <= '0;
            retire_cnt_reg <= '0;
        end else begin
            if (wb.flush) begin
                valid_reg <= 1'b0;
            end else if (!wb.stall) begin
                valid_reg    <= wb.in_valid;
                regwrite_reg <= wb.regwrite;
                rd_reg       <= wb.rd;
                memtoreg_reg <= wb.memtoreg;
                sel_reg      <= wb.readdatasel;
                alu_reg      <= wb.aluresult;
                rdata_reg    <= wb.readdata;
                pc4_reg      <= wb.pcplus4;
                pcjump_reg   <= wb.pcjump;
            end
            if (retire) begin
                retire_cnt_reg <= retire_cnt_reg + 32'd1;
            end
        end
    end

    // Split the captured memory word into byte and halfword lanes
    logic [7:0]  byte_lane [NBYTES];
    logic [15:0] half_lane [NHALFS];

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_byte
            assign byte_lane[gi] = rdata_reg[gi*8 +: 8];
        end
        for (gi = 0; gi < NHALFS; gi++) begin : g_half
            assign half_lane[gi] = rdata_reg[gi*16 +: 16];
        end
    endgenerate

    logic [1:0]  off;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    assign off      = alu_reg[1:0];
    assign sel_byte = byte_lane[off];
    assign sel_half = half_lane[off[1]];

    // Load extraction; undefined funct3 codes fall back to the whole word
    logic [DATA_W-1:0] load_data;
    always_comb begin
        load_data = rdata_reg;
        case (sel_reg)
            F3_LB:   load_data = {{(DATA_W-8){sel_byte[7]}}, sel_byte};
            F3_LBU:  load_data = {{(DATA_W-8){1'b0}}, sel_byte};
            F3_LH:   load_data = {{(DATA_W-16){sel_half[15]}}, sel_half};
            F3_LHU:  load_data = {{(DATA_W-16){1'b0}}, sel_half};
            default: load_data = rdata_reg;
        endcase
    end

    // Write-back value selection
    logic [DATA_W-1:0] wdata;
    always_comb begin
        wdata = alu_reg;
        case (memtoreg_reg)
            2'b00: wdata = alu_reg;
            2'b01: wdata = load_data;
            2'b10: wdata = DATA_W'(pc4_reg);
            2'b11: wdata = DATA_W'(pcjump_reg);
            default: wdata = alu_reg;
        endcase
    end

    // A misaligned load is reported but suppresses the register write
    logic half_load;
    logic mis;
    assign half_load = (sel_reg == F3_LH) | (sel_reg == F3_LHU);
    assign mis = valid_reg & (memtoreg_reg == 2'b01) &
                 ((half_load & off[0]) | ((sel_reg == F3_LW) & (off != 2'b00)));

    assign wb.rf_we       = valid_reg & regwrite_reg & (rd_reg != '0) & ~mis;
    assign wb.rf_waddr    = valid_reg ? rd_reg : '0;
    assign wb.rf_wdata    = wdata;
    assign wb.ld_misalign = mis;
    assign wb.retire_cnt  = retire_cnt_reg;
endmodule
